// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame constants and parity mode.
package uart_pkg;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 5208;

  typedef enum logic {
    PARITY_EVEN,
    PARITY_ODD
  } parity_mode_t;

  localparam parity_mode_t PARITY_MODE = PARITY_EVEN;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  // Expected parity bit for a data byte under the given mode.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input parity_mode_t mode);
    return (^d) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for an asynchronous single-bit input; all stages reset high.
module bit_synchronizer #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk) begin
    if (reset) begin
      stages <= '1;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_parity.sv
// UART receiver: 1 start, 8 data (LSB first), 1 even parity, 1 stop bit, with sticky flags.
module uart_rx_parity
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  input  logic       clear_interrupt,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_interrupt,
  output logic       parity_error,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned    CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

  logic                 rxs;
  uart_rx_state_t       state, state_next;
  logic [CW-1:0]        cnt, cnt_next;
  logic [2:0]           bit_idx, bit_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 par_err, par_err_next;
  logic                 deliver;

  bit_synchronizer #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (serial_in),
    .q    (rxs)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par_err <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
      par_err <= par_err_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_next     = bit_idx;
    shift_next   = shift;
    par_err_next = par_err;
    deliver      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxs) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt == HALF) begin
          cnt_next = '0;
          if (!rxs) begin
            state_next = DATA;
            bit_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_next            = '0;
          shift_next[bit_idx] = rxs;
          if (bit_idx == LAST_BIT) begin
            state_next = PARITY;
          end else begin
            bit_next = bit_idx + 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      PARITY: begin
        if (cnt == LAST) begin
          cnt_next     = '0;
          par_err_next = rxs ^ parity_bit(shift, PARITY_MODE);
          state_next   = STOP;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_next   = '0;
          deliver    = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sticky flags follow rx_valid, so a clear arriving during the rx_valid cycle loses to the set
  // and overrun sees the flag value from before that clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      rx_interrupt  <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      rx_valid <= deliver;
      if (deliver) begin
        rx_data       <= shift;
        parity_error  <= par_err;
        framing_error <= ~rxs;
      end
      rx_interrupt <= rx_valid | (rx_interrupt & ~clear_interrupt);
      overrun      <= (rx_valid & rx_interrupt) | (overrun & ~clear_interrupt);
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_parity.sv
// Directed self-checking bench for uart_rx_parity at a shortened bit period.
module tb_uart_rx_parity;

  localparam int unsigned CPB  = 32;
  localparam int unsigned SYNC = 2;
  localparam int unsigned HALF = (CPB - 1) / 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       serial_in = 1'b1;
  logic       clr_manual = 1'b0;
  logic       clr_auto = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_interrupt, parity_error, framing_error, overrun, busy;

  int          errors = 0;
  int          checks = 0;
  int unsigned valid_count = 0;
  int unsigned auto_mode = 0;
  logic        prev_valid = 1'b0;
  logic [7:0]  byte_q[$];

  always #5 clk = ~clk;

  uart_rx_parity #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .serial_in      (serial_in),
    .clear_interrupt(clr_manual | clr_auto),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_interrupt   (rx_interrupt),
    .parity_error   (parity_error),
    .framing_error  (framing_error),
    .overrun        (overrun),
    .busy           (busy)
  );

  // Records every valid cycle; auto_mode 1 clears the cycle after rx_valid, mode 2 during it.
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_count++;
      byte_q.push_back(rx_data);
    end
    if (auto_mode == 1) clr_auto = prev_valid;
    else if (auto_mode == 2) clr_auto = rx_valid;
    else clr_auto = 1'b0;
    prev_valid = rx_valid;
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      serial_in = bits[i];
      tick(CPB);
    end
    serial_in = 1'b1;
  endtask

  task automatic pulse_clear();
    clr_manual = 1'b1;
    tick(1);
    clr_manual = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    checks++; if ({rx_interrupt, overrun} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {rx_interrupt, overrun}); end
    checks++; if ({parity_error, framing_error} !== 2'b00) begin errors++; $display("FAIL reset_errors: got %b want 00", {parity_error, framing_error}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_single();
    int unsigned base;
    base = valid_count;
    send_frame(8'h01, 1'b1, 1'b1);
    tick(3);
    checks++; if (valid_count - base !== 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", valid_count - base); end
    checks++; if (rx_data !== 8'h01) begin errors++; $display("FAIL single_data: got %h want 01", rx_data); end
    checks++; if ({parity_error, framing_error} !== 2'b00) begin errors++; $display("FAIL single_errors: got %b want 00", {parity_error, framing_error}); end
    checks++; if (rx_interrupt !== 1'b1) begin errors++; $display("FAIL single_irq: got %b want 1", rx_interrupt); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL single_overrun: got %b want 0", overrun); end
    pulse_clear();
    checks++; if (rx_interrupt !== 1'b0) begin errors++; $display("FAIL single_irq_clear: got %b want 0", rx_interrupt); end
    checks++; if (rx_data !== 8'h01) begin errors++; $display("FAIL single_data_kept: got %h want 01", rx_data); end
  endtask

  task automatic test_back_to_back();
    int unsigned base, idx;
    logic [7:0] b;
    base = valid_count;
    idx  = byte_q.size();
    auto_mode = 1;
    for (int i = 1; i <= 16; i++) begin
      b = 8'(i);
      send_frame(b, ^b, 1'b1);
      tick(1);
    end
    tick(4);
    auto_mode = 0;
    checks++; if (valid_count - base !== 16) begin errors++; $display("FAIL b2b_pulses: got %0d want 16", valid_count - base); end
    for (int i = 1; i <= 16; i++) begin
      b = (idx + i - 1 < byte_q.size()) ? byte_q[idx + i - 1] : 8'hxx;
      checks++; if (b !== 8'(i)) begin errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, b, 8'(i)); end
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    checks++; if (rx_interrupt !== 1'b0) begin errors++; $display("FAIL b2b_irq: got %b want 0", rx_interrupt); end
  endtask

  task automatic test_parity();
    send_frame(8'h03, 1'b1, 1'b1);
    tick(3);
    checks++; if (rx_data !== 8'h03) begin errors++; $display("FAIL par_bad_data: got %h want 03", rx_data); end
    checks++; if (parity_error !== 1'b1) begin errors++; $display("FAIL par_bad_flag: got %b want 1", parity_error); end
    checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL par_bad_frame: got %b want 0", framing_error); end
    pulse_clear();
    checks++; if (parity_error !== 1'b1) begin errors++; $display("FAIL par_flag_kept: got %b want 1", parity_error); end
    send_frame(8'h07, 1'b1, 1'b1);
    tick(3);
    checks++; if (rx_data !== 8'h07) begin errors++; $display("FAIL par_good_data: got %h want 07", rx_data); end
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL par_good_flag: got %b want 0", parity_error); end
    pulse_clear();
  endtask

  task automatic test_framing();
    int unsigned base;
    base = valid_count;
    send_frame(8'hA5, 1'b0, 1'b0);
    tick(CPB);
    checks++; if (valid_count - base !== 1) begin errors++; $display("FAIL frame_pulses: got %0d want 1", valid_count - base); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL frame_data: got %h want a5", rx_data); end
    checks++; if (framing_error !== 1'b1) begin errors++; $display("FAIL frame_flag: got %b want 1", framing_error); end
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL frame_parity: got %b want 0", parity_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy: got %b want 0", busy); end
    pulse_clear();
  endtask

  task automatic test_glitch();
    int unsigned base;
    base = valid_count;
    serial_in = 1'b0;
    tick(6);
    serial_in = 1'b1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b want 1", busy); end
    tick(HALF + SYNC + 2 - 6);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low: got %b want 0", busy); end
    tick(CPB);
    checks++; if (valid_count - base !== 0) begin errors++; $display("FAIL glitch_pulses: got %0d want 0", valid_count - base); end
    checks++; if (rx_interrupt !== 1'b0) begin errors++; $display("FAIL glitch_irq: got %b want 0", rx_interrupt); end
  endtask

  task automatic test_overrun();
    send_frame(8'h0A, 1'b0, 1'b1);
    tick(2);
    checks++; if ({rx_interrupt, overrun} !== 2'b10) begin errors++; $display("FAIL ovr_first: got %b want 10", {rx_interrupt, overrun}); end
    send_frame(8'h0B, 1'b1, 1'b1);
    tick(2);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
    checks++; if (rx_data !== 8'h0B) begin errors++; $display("FAIL ovr_data: got %h want 0b", rx_data); end
    auto_mode = 2;
    send_frame(8'h0C, 1'b0, 1'b1);
    tick(2);
    auto_mode = 0;
    checks++; if (rx_interrupt !== 1'b1) begin errors++; $display("FAIL ovr_set_wins_irq: got %b want 1", rx_interrupt); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins_ovr: got %b want 1", overrun); end
    checks++; if (rx_data !== 8'h0C) begin errors++; $display("FAIL ovr_third_data: got %h want 0c", rx_data); end
  endtask

  task automatic test_reset_midframe();
    int unsigned base;
    base = valid_count;
    serial_in = 1'b0;
    tick(CPB);
    serial_in = 1'b1;
    tick(4 * CPB + CPB / 2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h want 00", rx_data); end
    checks++; if ({rx_interrupt, overrun} !== 2'b00) begin errors++; $display("FAIL mid_rst_flags: got %b want 00", {rx_interrupt, overrun}); end
    checks++; if ({rx_valid, parity_error, framing_error, busy} !== 4'b0000) begin errors++; $display("FAIL mid_rst_other: got %b want 0000", {rx_valid, parity_error, framing_error, busy}); end
    tick(2 * CPB);
    checks++; if (valid_count - base !== 0) begin errors++; $display("FAIL mid_no_pulse: got %0d want 0", valid_count - base); end
    send_frame(8'h55, 1'b0, 1'b1);
    tick(3);
    checks++; if (valid_count - base !== 1) begin errors++; $display("FAIL mid_next_pulses: got %0d want 1", valid_count - base); end
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL mid_next_data: got %h want 55", rx_data); end
    checks++; if ({parity_error, framing_error} !== 2'b00) begin errors++; $display("FAIL mid_next_errors: got %b want 00", {parity_error, framing_error}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_framing();
    test_glitch();
    test_overrun();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
